// File: rtl/sort_engine_scheduler.sv
// Shares one bubble_sort engine between NUM_REQ requesters.
// Round-robin grant latches the winner's array, pulses the engine start,
// waits for the low-then-high `last` sequence and returns the sorted array
// tagged with the requester index. A watchdog aborts a hung sort.
module sort_engine_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*64-1:0]   req_data,
   output logic [NUM_REQ-1:0]      gnt,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [63:0]             rsp_data,
   output logic                    rsp_err,
   output logic                    busy,
   output logic [63:0]             srt_data,
   output logic                    srt_en,
   input  logic [63:0]             srt_data_sort,
   input  logic                    srt_last
);

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_LOW,
      S_WAIT_HIGH,
      S_RESP
   } state_t;

   // One arbitration candidate: the requester index, the pointer value that
   // follows it, its one-hot grant and its array slice.
   typedef struct packed {
      logic                found;
      logic [ID_W-1:0]     idx;
      logic [ID_W-1:0]     nxt;
      logic [NUM_REQ-1:0]  onehot;
      logic [63:0]         data;
   } pick_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [63:0]         srt_data_q, srt_data_d;
   logic [63:0]         rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   pick_t               hi_pick, lo_pick, pick;
   logic                timeout_hit;

   // Round-robin search: the lowest requester at or above the pointer wins,
   // otherwise the lowest one below it (the wrap-around part of the search).
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      hi_pick = '0;
      lo_pick = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i]) begin
            if (ID_W'(i) >= ptr_q) begin
               if (!hi_pick.found) begin
                  hi_pick.found     = 1'b1;
                  hi_pick.idx       = ID_W'(i);
                  hi_pick.nxt       = (i == NUM_REQ - 1) ? '0 : ID_W'(i + 1);
                  hi_pick.onehot[i] = 1'b1;
                  hi_pick.data      = req_data[i*64 +: 64];
               end
            end else if (!lo_pick.found) begin
               lo_pick.found     = 1'b1;
               lo_pick.idx       = ID_W'(i);
               lo_pick.nxt       = ID_W'(i + 1);
               lo_pick.onehot[i] = 1'b1;
               lo_pick.data      = req_data[i*64 +: 64];
            end
         end
      end
      pick = hi_pick.found ? hi_pick : lo_pick;
   end

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state logic: arbitration, launch, the two engine handshake phases
   // with a shared watchdog, and the held response.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      srt_data_d = srt_data_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (pick.found) begin
               id_d       = pick.idx;
               ptr_d      = pick.nxt;
               srt_data_d = pick.data;
               state_d    = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout_hit) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = S_RESP;
            end else if (!srt_last) begin
               state_d = S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A completion seen on the watchdog's last cycle still counts.
            if (srt_last) begin
               rsp_data_d = srt_data_sort;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end else if (timeout_hit) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_err_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         id_q       <= '0;
         srt_data_q <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         srt_data_q <= srt_data_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign gnt       = (state_q == S_IDLE) ? pick.onehot : '0;
   assign srt_en    = (state_q == S_LAUNCH);
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_id    = id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign srt_data  = srt_data_q;

endmodule

// File: tb/tb_sort_engine_scheduler.sv
// Directed bench for sort_engine_scheduler with a behavioural bubble_sort
// stand-in (start on en, last low, then high with the sorted array after a
// programmable delay) and a manual override for srt_last/srt_data_sort.
module tb_sort_engine_scheduler;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 50;

   localparam logic [63:0] D0 = 64'h0807060504030201, S0 = 64'h0102030405060708;
   localparam logic [63:0] D1 = 64'hFF00FF00FF00FF00, S1 = 64'h00000000FFFFFFFF;
   localparam logic [63:0] D2 = 64'h0102030405060708, S2 = 64'h0102030405060708;
   localparam logic [63:0] D3 = 64'h5555555555555555, S3 = 64'h5555555555555555;
   localparam logic [63:0] DA = 64'h190A282D3C1403C8, SA = 64'h030A1419282D3CC8;
   localparam logic [63:0] MS = 64'h0123456789ABCDEF;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NUM_REQ-1:0]    req = '0;
   logic [NUM_REQ*64-1:0] req_data = '0;
   logic [NUM_REQ-1:0]    gnt;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b1;
   logic [ID_W-1:0]       rsp_id;
   logic [63:0]           rsp_data;
   logic                  rsp_err;
   logic                  busy;
   logic [63:0]           srt_data;
   logic                  srt_en;
   logic [63:0]           srt_data_sort;
   logic                  srt_last;

   int n_vec = 0;
   int n_err = 0;

   // Engine stand-in controls
   int          eng_delay  = 30;
   bit          eng_never  = 1'b0;
   bit          eng_manual = 1'b0;
   logic        man_last   = 1'b1;
   logic [63:0] man_sort   = '0;
   logic        eng_last_q;
   logic [63:0] eng_in_q, eng_out_q;
   int          eng_cnt;
   bit          eng_busy_q;

   always #5 clk = ~clk;

   sort_engine_scheduler #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .req_data      (req_data),
      .gnt           (gnt),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .busy          (busy),
      .srt_data      (srt_data),
      .srt_en        (srt_en),
      .srt_data_sort (srt_data_sort),
      .srt_last      (srt_last)
   );

   assign srt_last      = eng_manual ? man_last : eng_last_q;
   assign srt_data_sort = eng_manual ? man_sort : eng_out_q;

   function automatic logic [63:0] sort8(input logic [63:0] x);
      logic [7:0]  b [8];
      logic [7:0]  t;
      logic [63:0] r;
      for (int i = 0; i < 8; i++) b[i] = x[8*i +: 8];
      for (int i = 0; i < 7; i++)
         for (int j = 0; j < 7 - i; j++)
            if (b[j] > b[j+1]) begin
               t = b[j]; b[j] = b[j+1]; b[j+1] = t;
            end
      r = '0;
      for (int i = 0; i < 8; i++) r[63-8*i -: 8] = b[i];
      return r;
   endfunction

   // Behavioural engine: last idles high, drops after en, rises when done.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_last_q <= 1'b1;
         eng_in_q   <= '0;
         eng_out_q  <= '0;
         eng_cnt    <= 0;
         eng_busy_q <= 1'b0;
      end else if (srt_en) begin
         eng_last_q <= 1'b0;
         eng_in_q   <= srt_data;
         eng_cnt    <= eng_delay;
         eng_busy_q <= !eng_never;
      end else if (eng_busy_q) begin
         if (eng_cnt <= 1) begin
            eng_last_q <= 1'b1;
            eng_out_q  <= sort8(eng_in_q);
            eng_busy_q <= 1'b0;
         end else begin
            eng_cnt <= eng_cnt - 1;
         end
      end
   end

   task automatic set_data(input int i, input logic [63:0] d);
      req_data[64*i +: 64] = d;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req        = '0;
      rsp_ready  = 1'b1;
      eng_manual = 1'b0;
      eng_never  = 1'b0;
      man_last   = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Waits (bounded) for rsp_valid at negedges; returns elapsed cycles.
   task automatic wait_rsp(input int limit, output int cycles);
      cycles = 0;
      while (rsp_valid !== 1'b1 && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, srt_en, srt_data} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got gnt=%b v=%b id=%0d d=%h e=%b busy=%b en=%b sd=%h, expected all zero",
                  gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, srt_en, srt_data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || gnt !== '0) begin
         n_err++;
         $display("FAIL reset_idle: got busy=%b gnt=%b, expected 0/0000", busy, gnt);
      end
   endtask

   task automatic test_single();
      int cyc;
      do_reset();
      eng_delay = 30;
      set_data(2, DA);
      req = 4'b0100;
      #1;
      n_vec++;
      if (gnt !== 4'b0100) begin
         n_err++; $display("FAIL single_gnt: got %b expected 0100", gnt);
      end
      @(negedge clk);
      req = '0;
      n_vec++;
      if (srt_en !== 1'b1 || gnt !== '0 || busy !== 1'b1) begin
         n_err++; $display("FAIL single_launch: got en=%b gnt=%b busy=%b expected 1/0000/1", srt_en, gnt, busy);
      end
      n_vec++;
      if (srt_data !== DA) begin
         n_err++; $display("FAIL single_srt_data: got %h expected %h", srt_data, DA);
      end
      @(negedge clk);
      n_vec++;
      if (srt_en !== 1'b0) begin
         n_err++; $display("FAIL single_en_pulse: got %b expected 0", srt_en);
      end
      wait_rsp(200, cyc);
      n_vec++;
      if (cyc + 2 != 33) begin
         n_err++; $display("FAIL single_latency: got %0d expected 33", cyc + 2);
      end
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_err !== 1'b0) begin
         n_err++; $display("FAIL single_rsp: got v=%b id=%0d err=%b expected 1/2/0", rsp_valid, rsp_id, rsp_err);
      end
      n_vec++;
      if (rsp_data !== SA) begin
         n_err++; $display("FAIL single_rsp_data: got %h expected %h", rsp_data, SA);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL single_release: got v=%b busy=%b expected 0/0", rsp_valid, busy);
      end
   endtask

   task automatic test_round_robin();
      int          exp_order [5] = '{0, 1, 2, 3, 0};
      logic [63:0] exp_sort  [4] = '{S0, S1, S2, S3};
      int          got_order [5] = '{default: -1};
      int          n_gnt = 0, n_rsp = 0, en_cnt = 0, gidx = 0;
      bit          outstanding = 1'b0, drop = 1'b0, done = 1'b0;
      do_reset();
      eng_delay = 3;
      set_data(0, D0); set_data(1, D1); set_data(2, D2); set_data(3, D3);
      req = 4'b1111;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         if (drop) req = '0;
         #1;
         if (gnt !== '0) begin
            n_vec++;
            if (outstanding || $countones(gnt) != 1) begin
               n_err++; $display("FAIL rr_gnt_legal: got gnt=%b outstanding=%b expected one-hot with no job in flight", gnt, outstanding);
            end
            for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gidx = i;
            if (n_gnt < 5) got_order[n_gnt] = gidx;
            n_gnt++;
            outstanding = 1'b1;
            en_cnt = 0;
            if (n_gnt == 5) drop = 1'b1;
         end
         if (srt_en === 1'b1) en_cnt++;
         if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            n_vec++;
            if (en_cnt != 1) begin
               n_err++; $display("FAIL rr_en_count: got %0d expected 1", en_cnt);
            end
            n_vec++;
            if (n_rsp < 5 && (int'(rsp_id) != exp_order[n_rsp] || rsp_data !== exp_sort[exp_order[n_rsp]])) begin
               n_err++; $display("FAIL rr_rsp: got id=%0d data=%h expected id=%0d data=%h",
                                 rsp_id, rsp_data, exp_order[n_rsp], exp_sort[exp_order[n_rsp]]);
            end
            outstanding = 1'b0;
            n_rsp++;
            if (n_rsp == 5) done = 1'b1;
         end
         @(negedge clk);
      end
      req = '0;
      n_vec++;
      if (n_gnt != 5 || n_rsp != 5) begin
         n_err++; $display("FAIL rr_counts: got %0d grants %0d responses expected 5/5", n_gnt, n_rsp);
      end
      for (int k = 0; k < 5; k++) begin
         n_vec++;
         if (got_order[k] != exp_order[k]) begin
            n_err++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, got_order[k], exp_order[k]);
         end
      end
   endtask

   task automatic test_back_pressure();
      int cyc;
      do_reset();
      eng_delay = 2;
      rsp_ready = 1'b0;
      set_data(1, D0); set_data(3, D1);
      req = 4'b1010;
      #1;
      n_vec++;
      if (gnt !== 4'b0010) begin
         n_err++; $display("FAIL bp_gnt1: got %b expected 0010", gnt);
      end
      @(negedge clk);
      req = 4'b1000;
      wait_rsp(100, cyc);
      for (int i = 0; i < 20; i++) begin
         n_vec++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== S0 || rsp_err !== 1'b0 ||
             gnt !== '0 || srt_en !== 1'b0) begin
            n_err++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h gnt=%b en=%b expected 1/1/%h/0000/0",
                              i, rsp_valid, rsp_id, rsp_data, gnt, srt_en, S0);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0 || gnt !== 4'b1000) begin
         n_err++; $display("FAIL bp_release: got v=%b gnt=%b expected 0/1000", rsp_valid, gnt);
      end
      @(negedge clk);
      req = '0;
      wait_rsp(100, cyc);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== S1) begin
         n_err++; $display("FAIL bp_next: got v=%b id=%0d d=%h expected 1/3/%h", rsp_valid, rsp_id, rsp_data, S1);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int cyc;
      do_reset();
      eng_never = 1'b1;
      set_data(0, D0);
      req = 4'b0001;
      #1;
      n_vec++;
      if (gnt !== 4'b0001) begin
         n_err++; $display("FAIL to_gnt: got %b expected 0001", gnt);
      end
      @(negedge clk);
      req = '0;
      @(negedge clk);
      wait_rsp(200, cyc);
      n_vec++;
      if (cyc + 2 != 52) begin
         n_err++; $display("FAIL to_latency: got %0d expected 52", cyc + 2);
      end
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 2'd0) begin
         n_err++; $display("FAIL to_rsp: got v=%b err=%b d=%h id=%0d expected 1/1/0/0", rsp_valid, rsp_err, rsp_data, rsp_id);
      end
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
         n_err++; $display("FAIL to_clear: got v=%b err=%b expected 0/0", rsp_valid, rsp_err);
      end
      eng_never = 1'b0;
   endtask

   task automatic test_timeout_boundary();
      do_reset();
      eng_manual = 1'b1;
      man_last   = 1'b1;
      man_sort   = MS;
      set_data(2, D2);
      req = 4'b0100;
      @(negedge clk);
      req = '0;
      man_last = 1'b0;
      @(negedge clk);
      repeat (49) @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL tob_early: got v=%b expected 0", rsp_valid);
      end
      man_last = 1'b1;
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== MS || rsp_id !== 2'd2) begin
         n_err++; $display("FAIL tob_rsp: got v=%b err=%b d=%h id=%0d expected 1/0/%h/2", rsp_valid, rsp_err, rsp_data, rsp_id, MS);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_sort();
      int cyc;
      do_reset();
      eng_delay = 30;
      set_data(2, D2);
      req = 4'b0100;
      @(negedge clk);
      req = '0;
      repeat (8) @(negedge clk);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL rm_busy: got %b expected 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, srt_en, srt_data} !== '0) begin
         n_err++; $display("FAIL rm_outputs: got gnt=%b v=%b id=%0d d=%h e=%b busy=%b en=%b sd=%h, expected all zero",
                           gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, srt_en, srt_data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      set_data(1, D1); set_data(3, D3);
      req = 4'b1010;
      #1;
      n_vec++;
      if (gnt !== 4'b0010) begin
         n_err++; $display("FAIL rm_ptr_restart: got %b expected 0010", gnt);
      end
      @(negedge clk);
      req = '0;
      wait_rsp(100, cyc);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== S1 || rsp_err !== 1'b0) begin
         n_err++; $display("FAIL rm_rsp: got v=%b id=%0d d=%h err=%b expected 1/1/%h/0", rsp_valid, rsp_id, rsp_data, rsp_err, S1);
      end
      @(negedge clk);
   endtask

   task automatic test_spurious_last();
      bit bad = 1'b0;
      do_reset();
      eng_manual = 1'b1;
      man_last   = 1'b0;
      man_sort   = MS;
      @(negedge clk);
      man_last = 1'b1;
      @(negedge clk);
      man_last = 1'b0;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL sp_idle_glitch: got busy=%b v=%b expected 0/0", busy, rsp_valid);
      end
      man_last = 1'b1;
      set_data(0, D3);
      req = 4'b0001;
      #1;
      n_vec++;
      if (gnt !== 4'b0001) begin
         n_err++; $display("FAIL sp_gnt: got %b expected 0001", gnt);
      end
      @(negedge clk);
      req = '0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
         n_err++; $display("FAIL sp_high_ignored: got an early response expected none while last stays high");
      end
      man_last = 1'b0;
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL sp_low_phase: got v=%b expected 0", rsp_valid);
      end
      man_last = 1'b1;
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== MS || rsp_err !== 1'b0 || rsp_id !== 2'd0) begin
         n_err++; $display("FAIL sp_rsp: got v=%b d=%h err=%b id=%0d expected 1/%h/0/0", rsp_valid, rsp_data, rsp_err, rsp_id, MS);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_timeout();
      test_timeout_boundary();
      test_reset_mid_sort();
      test_spurious_last();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sort_engine_scheduler.md
Name: sort_engine_scheduler

Overview:
- Shares one bubble_sort engine (64-bit packed input of 8 unsigned bytes, single-cycle `en` start, `last` completion flag) between NUM_REQ requesters.
- Round-robin arbitration selects a requester and latches its array.
- Pulses the engine start, waits for completion, then returns the sorted array tagged with the requester ID.
- A watchdog flags a hung sort.
- Sits between client blocks and the bubble_sort instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT, 255, max cycles waiting on the engine before abort (1..65535).

Ports:
- clk  input  1  system clock
- rst_n  input  1  async active-low reset
- req  input  NUM_REQ  per-requester sort request level; held until gnt
- req_data  input  NUM_REQ*64  per-requester unsorted array; slice i = bits [64i+63:64i]
- gnt  output  NUM_REQ  one-hot, one-cycle pulse; request accepted and data latched
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_W  requester index of the result
- rsp_data  output  64  sorted array (engine data_sort_o capture)
- rsp_err  output  1  result aborted by timeout; rsp_data = 0
- busy  output  1  high in any state except IDLE
- srt_data  output  64  to engine data
- srt_en  output  1  to engine en
- srt_data_sort  input  64  from engine data_sort_o
- srt_last  input  1  from engine last

Behaviour:
Reset (async, rst_n low):
- State = IDLE.
- gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, busy = 0.
- srt_en = 0, srt_data = 0.
- Round-robin pointer = 0; timeout counter = 0.

Arbitration (IDLE only):
- Search starts at the pointer and takes the first i with req[i] = 1, wrapping modulo NUM_REQ.
- On grant:
  - gnt[i] = 1 for one cycle.
  - req_data slice i is latched into srt_data.
  - ID register = i.
  - Pointer = (i+1) mod NUM_REQ.
  - Go to LAUNCH.
- No req: stay in IDLE; the pointer does not move.

State machine:
- IDLE -> LAUNCH on grant.
- LAUNCH:
  - srt_en = 1 for exactly one cycle; srt_data stays stable.
  - Clear the timeout counter.
  - Go to WAIT_LOW.
- WAIT_LOW:
  - Wait for srt_last = 0 (engine acknowledged start).
  - If srt_last is already 0 at entry, go to WAIT_HIGH the next cycle.
- WAIT_HIGH:
  - Wait for srt_last = 1.
  - On the cycle srt_last = 1: capture srt_data_sort into rsp_data, rsp_err = 0, go to RESP.
- Timeout:
  - The counter increments every cycle in WAIT_LOW and WAIT_HIGH.
  - On reaching TIMEOUT: rsp_data = 0, rsp_err = 1, go to RESP.
  - A completion on the same cycle as the timeout wins (err = 0).
- RESP:
  - rsp_valid = 1; rsp_id, rsp_data and rsp_err are held stable.
  - On rsp_valid && rsp_ready: rsp_valid = 0 the next cycle, rsp_err cleared, go to IDLE.
  - Back-pressure is unbounded.

Timing and ordering rules:
- srt_data is held from grant until return to IDLE.
- Minimum request-to-rsp_valid latency: 4 cycles plus engine time (grant, LAUNCH, WAIT_LOW, WAIT_HIGH capture).
- Only one job is in flight; req is ignored outside IDLE and gnt stays 0 there.
- A requester may deassert req before gnt; it is simply not selected.
- A requester whose req is still high after its own response is not served again until every other pending requester has been served once.
- The first arbitration in IDLE after RESP uses the updated pointer; no grant is issued in the RESP->IDLE transition cycle itself.
- srt_last glitches in IDLE, LAUNCH or RESP are ignored.

Reset mid-operation:
- All state clears immediately; srt_en drops.
- Any pending response is lost.
- The engine is reset by the same rst_n.

Test Plan:
- Single requester: NUM_REQ=4, req[2]=1 with data {25,10,40,45,60,20,3,200}, engine model returning sorted {3,10,20,25,40,45,60,200} after 30 cycles -> gnt[2] one pulse, srt_en one pulse the cycle after, rsp_valid with rsp_id=2, rsp_data=sorted array, rsp_err=0.
- Round-robin fairness: req=4'b1111 held continuously, rsp_ready=1 -> grant order 0,1,2,3,0; exactly one srt_en per job; the next gnt is never issued before the previous rsp handshake.
- Back-pressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid/rsp_id/rsp_data stable, no new gnt, srt_en stays 0; rsp_ready=1 -> rsp_valid drops and the next grant follows in IDLE.
- Timeout: TIMEOUT=50, engine model never raises srt_last -> rsp_valid 50 cycles after entering WAIT_LOW with rsp_err=1 and rsp_data=0; srt_last rising on exactly cycle 50 -> rsp_err=0 with valid data.
- Reset mid-sort: assert rst_n=0 during WAIT_HIGH -> all outputs 0 asynchronously; after release, req[1] is served normally with pointer restarting at 0.
- Spurious last: srt_last pulses high in IDLE, and srt_last is already high at LAUNCH -> no response until a genuine low-then-high sequence is seen.
